// File: rtl/pipe_reg_skid_pkg.sv
// Shared cpu/isa encodings used by the skid pipeline register.
package pipe_reg_skid_pkg;

    localparam logic [1:0] CTRL_OP_NOP        = 2'd0;
    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd1;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_EXC_HOLD = 1'b1
    } skid_state_e;

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Upstream/downstream handshake and payload bundle of the skid pipeline register.
interface pipe_reg_skid_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 2,
    parameter int EXP_W      = 3,
    parameter int CNT_W      = 16
);
    logic                  InValid;
    logic                  InReady;
    logic [ADDR_W-1:0]     InPC;
    logic                  InEn;
    logic                  InBrFlag;
    logic [CTRL_W-1:0]     InCtrlOp;
    logic [REG_ADDR_W-1:0] InDstAddr;
    logic                  InGPRWE_;
    logic [EXP_W-1:0]      InExpCode;
    logic [DATA_W-1:0]     InOut;
    logic                  MissAlign;
    logic                  Flush;
    logic                  OutValid;
    logic                  OutReady;
    logic [ADDR_W-1:0]     OutPC;
    logic                  OutEn;
    logic                  OutBrFlag;
    logic [CTRL_W-1:0]     OutCtrlOp;
    logic [REG_ADDR_W-1:0] OutDstAddr;
    logic                  OutGPRWE_;
    logic [EXP_W-1:0]      OutExpCode;
    logic [DATA_W-1:0]     OutOut;
    logic                  ExcPending;
    logic [CNT_W-1:0]      StallCnt;

    modport master (
        output InValid, InPC, InEn, InBrFlag, InCtrlOp, InDstAddr, InGPRWE_,
               InExpCode, InOut, MissAlign, Flush, OutReady,
        input  InReady, OutValid, OutPC, OutEn, OutBrFlag, OutCtrlOp, OutDstAddr,
               OutGPRWE_, OutExpCode, OutOut, ExcPending, StallCnt
    );

    modport slave (
        input  InValid, InPC, InEn, InBrFlag, InCtrlOp, InDstAddr, InGPRWE_,
               InExpCode, InOut, MissAlign, Flush, OutReady,
        output InReady, OutValid, OutPC, OutEn, OutBrFlag, OutCtrlOp, OutDstAddr,
               OutGPRWE_, OutExpCode, OutOut, ExcPending, StallCnt
    );
endinterface

// File: rtl/pipe_payload_latch.sv
// One pipeline entry: a valid flag with async reset plus an unreset packed payload.
module pipe_payload_latch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)    valid <= 1'b0;
        else if (clear) valid <= 1'b0;
        else if (load)  valid <= 1'b1;
    end

    // Payload is only observed through valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) q <= d;
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Two-entry (main + skid) pipeline register with exception hold, flush and stall counter.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 2,
    parameter int EXP_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset_,
    pipe_reg_skid_if.slave bus
);

    localparam int W = ADDR_W + 3 + CTRL_W + REG_ADDR_W + EXP_W + DATA_W;

    logic [W-1:0]     in_beat, main_d, main_q, skid_q, rst_beat, out_beat;
    logic [EXP_W-1:0] beat_exp;
    logic             main_valid, skid_valid;
    logic             in_fire, out_fire, store;
    logic             main_load, main_clear, skid_load, skid_clear;
    logic [CNT_W-1:0] stall_cnt;
    skid_state_e      state_q, state_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rst_beat = {ADDR_W'(0), 1'b0, 1'b0, CTRL_W'(CTRL_OP_NOP), REG_ADDR_W'(0),
                       1'b1, EXP_W'(ISA_EXP_NO_EXP), DATA_W'(0)};

    always_comb begin
        in_beat = {bus.InPC, bus.InEn, bus.InBrFlag, bus.InCtrlOp, bus.InDstAddr,
                   bus.InGPRWE_, bus.InExpCode, bus.InOut};
        if (bus.MissAlign)
            in_beat = {bus.InPC, bus.InEn, bus.InBrFlag, CTRL_W'(CTRL_OP_NOP),
                       REG_ADDR_W'(0), 1'b1, EXP_W'(ISA_EXP_MISS_ALIGN), DATA_W'(0)};
    end

    assign beat_exp = in_beat[DATA_W +: EXP_W];
    assign in_fire  = bus.InValid & ~skid_valid;
    assign out_fire = main_valid & bus.OutReady;
    assign store    = in_fire & (state_q == ST_RUN);

    // Main refills whenever it is empty or draining: from skid first, else the new beat.
    assign main_load  = ~bus.Flush & (~main_valid | out_fire) & (skid_valid | store);
    assign main_d     = skid_valid ? skid_q : in_beat;
    assign main_clear = bus.Flush | (out_fire & ~skid_valid & ~store);
    assign skid_load  = ~bus.Flush & store & main_valid & ~out_fire;
    assign skid_clear = bus.Flush | (skid_valid & (~main_valid | out_fire));

    pipe_payload_latch #(.W(W)) u_main (
        .clk(clk), .reset_(reset_), .load(main_load), .clear(main_clear),
        .d(main_d), .valid(main_valid), .q(main_q)
    );

    pipe_payload_latch #(.W(W)) u_skid (
        .clk(clk), .reset_(reset_), .load(skid_load), .clear(skid_clear),
        .d(in_beat), .valid(skid_valid), .q(skid_q)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.Flush)
            state_d = ST_RUN;
        else if (state_q == ST_RUN && store && beat_exp != EXP_W'(ISA_EXP_NO_EXP))
            state_d = ST_EXC_HOLD;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)                         stall_cnt <= '0;
        else if (main_valid && !bus.OutReady) stall_cnt <= sat_inc(stall_cnt);
    end

    assign out_beat = main_valid ? main_q : rst_beat;

    assign {bus.OutPC, bus.OutEn, bus.OutBrFlag, bus.OutCtrlOp, bus.OutDstAddr,
            bus.OutGPRWE_, bus.OutExpCode, bus.OutOut} = out_beat;
    assign bus.OutValid   = main_valid;
    assign bus.InReady    = ~skid_valid;
    assign bus.ExcPending = (state_q == ST_EXC_HOLD);
    assign bus.StallCnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed vector bench for pipe_reg_skid: streaming, stalls, misalign hold, flush, counter, reset.
module tb_pipe_reg_skid;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    pipe_reg_skid_if #(.DATA_W(32), .ADDR_W(30), .REG_ADDR_W(5), .CTRL_W(2),
                       .EXP_W(3), .CNT_W(4)) bus ();

    pipe_reg_skid #(.DATA_W(32), .ADDR_W(30), .REG_ADDR_W(5), .CTRL_W(2),
                    .EXP_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset_(reset_), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          iv;
        logic [29:0] pc;
        bit          ordy;
        bit          ov;
        logic [29:0] opc;
        bit          ir;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [29:0] pc, input bit ordy,
                         input bit miss, input bit fl);
        bus.InValid   = iv;
        bus.InPC      = pc;
        bus.InOut     = {2'b00, pc} + 32'd100;
        bus.OutReady  = ordy;
        bus.MissAlign = miss;
        bus.Flush     = fl;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 30'h10, 1'b1, 1'b1, 30'h10, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 30'h11, 1'b1, 1'b1, 30'h11, 1'b1, 4'd0};
        vecs[2]  = '{1'b1, 30'h12, 1'b1, 1'b1, 30'h12, 1'b1, 4'd0};
        vecs[3]  = '{1'b1, 30'h13, 1'b1, 1'b1, 30'h13, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 30'h00, 1'b1, 1'b0, 30'h00, 1'b1, 4'd0};
        vecs[5]  = '{1'b1, 30'h30, 1'b1, 1'b1, 30'h30, 1'b1, 4'd0};
        vecs[6]  = '{1'b1, 30'h31, 1'b0, 1'b1, 30'h30, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 30'h32, 1'b0, 1'b1, 30'h30, 1'b0, 4'd2};
        vecs[8]  = '{1'b1, 30'h32, 1'b0, 1'b1, 30'h30, 1'b0, 4'd3};
        vecs[9]  = '{1'b1, 30'h32, 1'b1, 1'b1, 30'h31, 1'b1, 4'd3};
        vecs[10] = '{1'b1, 30'h32, 1'b1, 1'b1, 30'h32, 1'b1, 4'd3};
        vecs[11] = '{1'b0, 30'h00, 1'b1, 1'b0, 30'h00, 1'b1, 4'd3};

        reset_        = 1'b0;
        bus.InEn      = 1'b1;
        bus.InBrFlag  = 1'b0;
        bus.InCtrlOp  = 2'd2;
        bus.InDstAddr = 5'd3;
        bus.InGPRWE_  = 1'b0;
        bus.InExpCode = 3'd0;
        drive(1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.OutValid), 64'd0);
        check("rst_in_ready", 64'(bus.InReady), 64'd1);
        check("rst_stall_cnt", 64'(bus.StallCnt), 64'd0);
        check("rst_exc", 64'(bus.ExcPending), 64'd0);
        check("rst_gprwe", 64'(bus.OutGPRWE_), 64'd1);
        check("rst_ctrlop", 64'(bus.OutCtrlOp), 64'd0);
        #3 reset_ = 1'b1;
        tick();

        // streaming and stall vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(bus.OutValid), 64'(vecs[i].ov));
            check($sformatf("vec%0d_out_pc", i), 64'(bus.OutPC), 64'(vecs[i].opc));
            check($sformatf("vec%0d_out_data", i), 64'(bus.OutOut),
                  vecs[i].ov ? 64'(vecs[i].opc) + 64'd100 : 64'd0);
            check($sformatf("vec%0d_gprwe", i), 64'(bus.OutGPRWE_), vecs[i].ov ? 64'd0 : 64'd1);
            check($sformatf("vec%0d_in_ready", i), 64'(bus.InReady), 64'(vecs[i].ir));
            check($sformatf("vec%0d_stall_cnt", i), 64'(bus.StallCnt), 64'(vecs[i].cnt));
            check($sformatf("vec%0d_exc", i), 64'(bus.ExcPending), 64'd0);
        end

        // misaligned beat enters exception hold
        bus.InDstAddr = 5'd7;
        drive(1'b1, 30'h20, 1'b1, 1'b1, 1'b0);
        tick();
        bus.InDstAddr = 5'd3;
        check("miss_valid", 64'(bus.OutValid), 64'd1);
        check("miss_pc", 64'(bus.OutPC), 64'h20);
        check("miss_en", 64'(bus.OutEn), 64'd1);
        check("miss_dst", 64'(bus.OutDstAddr), 64'd0);
        check("miss_gprwe", 64'(bus.OutGPRWE_), 64'd1);
        check("miss_exp", 64'(bus.OutExpCode), 64'd1);
        check("miss_ctrlop", 64'(bus.OutCtrlOp), 64'd0);
        check("miss_data", 64'(bus.OutOut), 64'd0);
        check("miss_exc", 64'(bus.ExcPending), 64'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 30'h21 + 30'(i), 1'b1, 1'b0, 1'b0);
            tick();
            check($sformatf("hold%0d_valid", i), 64'(bus.OutValid), 64'd0);
            check($sformatf("hold%0d_exc", i), 64'(bus.ExcPending), 64'd1);
            check($sformatf("hold%0d_in_ready", i), 64'(bus.InReady), 64'd1);
        end
        drive(1'b0, 30'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold_drained", 64'(bus.OutValid), 64'd0);

        // flush leaves exception hold, then flush with both entries full
        drive(1'b0, 30'h0, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush1_exc", 64'(bus.ExcPending), 64'd0);
        drive(1'b1, 30'h40, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 30'h41, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_in_ready", 64'(bus.InReady), 64'd0);
        check("full_pc", 64'(bus.OutPC), 64'h40);
        drive(1'b1, 30'h42, 1'b0, 1'b0, 1'b1);
        tick();
        check("flush2_valid", 64'(bus.OutValid), 64'd0);
        check("flush2_in_ready", 64'(bus.InReady), 64'd1);
        check("flush2_exc", 64'(bus.ExcPending), 64'd0);
        check("flush2_cnt", 64'(bus.StallCnt), 64'd5);
        drive(1'b1, 30'h43, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_flush_valid", 64'(bus.OutValid), 64'd1);
        check("post_flush_pc", 64'(bus.OutPC), 64'h43);
        drive(1'b0, 30'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_flush_empty", 64'(bus.OutValid), 64'd0);

        // stall counter saturation over 20 stall cycles
        drive(1'b1, 30'h50, 1'b0, 1'b0, 1'b0);
        tick();
        check("sat_start", 64'(bus.StallCnt), 64'd5);
        drive(1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        check("sat_mid", 64'(bus.StallCnt), 64'd10);
        repeat (15) tick();
        check("sat_hold", 64'(bus.StallCnt), 64'd15);
        check("sat_pc", 64'(bus.OutPC), 64'h50);

        // asynchronous reset between edges
        drive(1'b1, 30'h51, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre_rst_in_ready", 64'(bus.InReady), 64'd0);
        #2 reset_ = 1'b0;
        #1;
        check("arst_valid", 64'(bus.OutValid), 64'd0);
        check("arst_in_ready", 64'(bus.InReady), 64'd1);
        check("arst_cnt", 64'(bus.StallCnt), 64'd0);
        check("arst_pc", 64'(bus.OutPC), 64'd0);
        check("arst_gprwe", 64'(bus.OutGPRWE_), 64'd1);
        drive(1'b0, 30'h0, 1'b1, 1'b0, 1'b0);
        #2 reset_ = 1'b1;
        tick();
        check("post_rst_empty", 64'(bus.OutValid), 64'd0);
        drive(1'b1, 30'h60, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_valid", 64'(bus.OutValid), 64'd1);
        check("post_rst_pc", 64'(bus.OutPC), 64'h60);
        check("post_rst_exc", 64'(bus.ExcPending), 64'd0);
        drive(1'b0, 30'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_drain", 64'(bus.OutValid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
